// File: rtl/sram_arbiter.sv
// sram_arbiter: arbitrates an instruction-fetch port and a data port onto a
// single asynchronous 32-bit SRAM. Data requests take priority. Each access
// runs through a fixed strobe sequence whose length is stretched by
// WAIT_CYCLES, and a one-cycle ready pulse goes to the owning requester.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   if_req_i, if_addr_i          fetch read request / byte address
//   if_rdata_o, if_ready_o       fetched word / completion pulse
//   dm_req_i, dm_we_i            data request / 1 = write
//   dm_addr_i, dm_wdata_i        data byte address / write data
//   dm_be_n_i                    byte enables, active-low
//   dm_rdata_o, dm_ready_o       read word / completion pulse
//   ram_addr_o, ram_be_n_o       SRAM word address / byte enables (active-low)
//   ram_ce_n_o, ram_oe_n_o,
//   ram_we_n_o                   SRAM strobes, active-low
//   ram_wdata_o, ram_data_oe_o   write data / bus drive enable
//   ram_rdata_i                  data sampled from the SRAM bus
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ready_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    input  logic [3:0]  dm_be_n_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ready_o,
    output logic [19:0] ram_addr_o,
    output logic [3:0]  ram_be_n_o,
    output logic        ram_ce_n_o,
    output logic        ram_oe_n_o,
    output logic        ram_we_n_o,
    output logic [31:0] ram_wdata_o,
    output logic        ram_data_oe_o,
    input  logic [31:0] ram_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    state_t      state;
    state_t      nxt;
    logic [2:0]  cnt;
    logic        cnt_done;
    logic        owner_dm;
    logic        grant_dm;
    logic        grant_if;

    // Only the SRAM word-address bits are used from the byte addresses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[31:22], if_addr_i[1:0],
                                dm_addr_i[31:22], dm_addr_i[1:0]};

    assign cnt_done = (cnt == 3'(WAIT_CYCLES));

    always_comb begin
        nxt      = state;
        grant_dm = 1'b0;
        grant_if = 1'b0;
        case (state)
            IDLE: begin
                if (dm_req_i) begin
                    grant_dm = 1'b1;
                    nxt      = dm_we_i ? WR_SETUP : READ;
                end else if (if_req_i) begin
                    grant_if = 1'b1;
                    nxt      = READ;
                end
            end
            READ:     if (cnt_done) nxt = DONE;
            WR_SETUP: nxt = WR_PULSE;
            WR_PULSE: if (cnt_done) nxt = WR_HOLD;
            WR_HOLD:  nxt = DONE;
            DONE:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // State, wait counter and the captured request. The counter restarts
    // on every state change so READ and WR_PULSE each last WAIT_CYCLES+1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            owner_dm    <= 1'b0;
            ram_addr_o  <= '0;
            ram_be_n_o  <= '1;
            ram_wdata_o <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt == state) ? cnt + 3'd1 : '0;
            if (grant_dm || grant_if) begin
                owner_dm   <= grant_dm;
                ram_addr_o <= grant_dm ? dm_addr_i[21:2] : if_addr_i[21:2];
                ram_be_n_o <= grant_dm ? dm_be_n_i : 4'h0;
                if (grant_dm)
                    ram_wdata_o <= dm_wdata_i;
            end
        end
    end

    // Strobes, bus enable and ready pulses are registered from the next
    // state, so each one is a flop output aligned with the state it marks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ram_ce_n_o    <= 1'b1;
            ram_oe_n_o    <= 1'b1;
            ram_we_n_o    <= 1'b1;
            ram_data_oe_o <= 1'b0;
            if_ready_o    <= 1'b0;
            dm_ready_o    <= 1'b0;
        end else begin
            ram_ce_n_o    <= !(nxt inside {READ, WR_SETUP, WR_PULSE, WR_HOLD});
            ram_oe_n_o    <= (nxt != READ);
            ram_we_n_o    <= (nxt != WR_PULSE);
            ram_data_oe_o <= (nxt inside {WR_SETUP, WR_PULSE, WR_HOLD});
            if_ready_o    <= (nxt == DONE) && !owner_dm;
            dm_ready_o    <= (nxt == DONE) && owner_dm;
        end
    end

    // Read data is captured on the last READ cycle and held until the
    // owner's next read completes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_rdata_o <= '0;
            dm_rdata_o <= '0;
        end else if (state == READ && cnt_done) begin
            if (owner_dm)
                dm_rdata_o <= ram_rdata_i;
            else
                if_rdata_o <= ram_rdata_i;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized self-checking bench for sram_arbiter.
// A WAIT_CYCLES=1 instance runs against a byte-writable SRAM bus model and a
// transaction-level golden memory; a WAIT_CYCLES=0 instance runs a
// back-to-back fetch stream against an address-derived data pattern.
module tb_sram_arbiter;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        if_req, if_ready, dm_req, dm_we, dm_ready;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be_n, ram_be_n;
    logic [19:0] ram_addr;
    logic        ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe;
    logic [31:0] ram_wdata, ram_rdata;

    logic        f_if_req, f_if_ready, f_dm_req, f_dm_we, f_dm_ready;
    logic [31:0] f_if_addr, f_if_rdata, f_dm_addr, f_dm_wdata, f_dm_rdata;
    logic [3:0]  f_dm_be_n, f_ram_be_n;
    logic [19:0] f_ram_addr;
    logic        f_ram_ce_n, f_ram_oe_n, f_ram_we_n, f_ram_data_oe;
    logic [31:0] f_ram_wdata, f_ram_rdata;

    logic [31:0] bus_mem [64];
    logic [31:0] gold    [64];
    logic [31:0] last_if_rdata, last_dm_rdata;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    sram_arbiter #(.WAIT_CYCLES(W)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_be_n_i(dm_be_n), .dm_rdata_o(dm_rdata), .dm_ready_o(dm_ready),
        .ram_addr_o(ram_addr), .ram_be_n_o(ram_be_n), .ram_ce_n_o(ram_ce_n),
        .ram_oe_n_o(ram_oe_n), .ram_we_n_o(ram_we_n), .ram_wdata_o(ram_wdata),
        .ram_data_oe_o(ram_data_oe), .ram_rdata_i(ram_rdata)
    );

    sram_arbiter #(.WAIT_CYCLES(0)) u_fast (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(f_if_req), .if_addr_i(f_if_addr), .if_rdata_o(f_if_rdata), .if_ready_o(f_if_ready),
        .dm_req_i(f_dm_req), .dm_we_i(f_dm_we), .dm_addr_i(f_dm_addr), .dm_wdata_i(f_dm_wdata),
        .dm_be_n_i(f_dm_be_n), .dm_rdata_o(f_dm_rdata), .dm_ready_o(f_dm_ready),
        .ram_addr_o(f_ram_addr), .ram_be_n_o(f_ram_be_n), .ram_ce_n_o(f_ram_ce_n),
        .ram_oe_n_o(f_ram_oe_n), .ram_we_n_o(f_ram_we_n), .ram_wdata_o(f_ram_wdata),
        .ram_data_oe_o(f_ram_data_oe), .ram_rdata_i(f_ram_rdata)
    );

    // SRAM bus models: the main one returns stored words, the fast one
    // returns a pattern derived from the word address.
    assign ram_rdata   = (!ram_ce_n && !ram_oe_n) ? bus_mem[ram_addr[5:0]] : 32'hBAD0_BAD0;
    assign f_ram_rdata = (!f_ram_ce_n && !f_ram_oe_n) ? {12'h0, f_ram_addr} : 32'hBAD0_BAD0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // SRAM write on an active write strobe, plus bus protocol invariants.
    always @(negedge clk) begin
        if (!ram_ce_n && !ram_we_n && ram_data_oe)
            for (int b = 0; b < 4; b++)
                if (!ram_be_n[b])
                    bus_mem[ram_addr[5:0]][8*b +: 8] = ram_wdata[8*b +: 8];
        if (!rst) begin
            check_eq("oe_with_data_oe", 32'(!ram_oe_n && ram_data_oe), 32'd0);
            check_eq("ready_overlap", 32'(if_ready && dm_ready), 32'd0);
            check_eq("strobe_without_ce", 32'((!ram_oe_n || !ram_we_n) && ram_ce_n), 32'd0);
            check_eq("we_without_data_oe", 32'(!ram_we_n && !ram_data_oe), 32'd0);
            check_eq("fast_oe_with_data_oe", 32'(!f_ram_oe_n && f_ram_data_oe), 32'd0);
        end
    end

    // One arbitration round: optional fetch and optional data request
    // raised together; checks order, latency, addresses, strobes and data.
    task automatic run_txn(input bit do_if, input logic [31:0] ia,
                           input bit do_dm, input bit dwe, input logic [31:0] da,
                           input logic [31:0] dwd, input logic [3:0] dbe);
        int  k, k_dm, k_if, we_low, doe_high, dm_lat, if_lat;
        bit  dm_pend, if_pend;
        check_eq("if_rdata_hold", if_rdata, last_if_rdata);
        check_eq("dm_rdata_hold", dm_rdata, last_dm_rdata);
        if_req = do_if; if_addr = ia;
        dm_req = do_dm; dm_we = dwe; dm_addr = da; dm_wdata = dwd; dm_be_n = dbe;
        dm_pend = do_dm; if_pend = do_if;
        k = 0; k_dm = 0; k_if = 0; we_low = 0; doe_high = 0;
        while ((dm_pend || if_pend) && k < 40) begin
            step();
            k++;
            if (!ram_we_n) we_low++;
            if (ram_data_oe) doe_high++;
            if (!ram_ce_n) begin
                check_eq("ram_addr", 32'(ram_addr), dm_pend ? 32'(da[21:2]) : 32'(ia[21:2]));
                check_eq("ram_be_n", 32'(ram_be_n), dm_pend ? 32'(dbe) : 32'd0);
                if (dm_pend && dwe)
                    check_eq("ram_wdata", ram_wdata, dwd);
            end
            if (dm_ready) begin
                check_eq("dm_ready_owner", 32'(dm_pend), 32'd1);
                k_dm = k; dm_pend = 1'b0; dm_req = 1'b0;
                if (dwe) begin
                    for (int b = 0; b < 4; b++)
                        if (!dbe[b]) gold[da[7:2]][8*b +: 8] = dwd[8*b +: 8];
                end else begin
                    check_eq("dm_rdata", dm_rdata, gold[da[7:2]]);
                    last_dm_rdata = dm_rdata;
                end
            end
            if (if_ready) begin
                check_eq("if_ready_owner", 32'(if_pend), 32'd1);
                check_eq("if_before_dm", 32'(dm_pend), 32'd0);
                k_if = k; if_pend = 1'b0; if_req = 1'b0;
                check_eq("if_rdata", if_rdata, gold[ia[7:2]]);
                last_if_rdata = if_rdata;
            end
        end
        check_eq("txn_timeout", 32'(dm_pend || if_pend), 32'd0);
        dm_lat = dwe ? W + 4 : W + 2;
        if_lat = do_dm ? dm_lat + 1 + W + 2 : W + 2;
        if (do_dm) check_eq("dm_latency", 32'(k_dm), 32'(dm_lat));
        if (do_if) check_eq("if_latency", 32'(k_if), 32'(if_lat));
        check_eq("we_n_low_cycles", 32'(we_low), (do_dm && dwe) ? 32'(W + 1) : 32'd0);
        check_eq("data_oe_cycles", 32'(doe_high), (do_dm && dwe) ? 32'(W + 3) : 32'd0);
        step();
        check_eq("ready_after_done", 32'(if_ready || dm_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, r2, old, a;
        int          k, last_k, cnt;
        rst = 1'b1;
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be_n = '1;
        f_if_req = 0; f_if_addr = 0; f_dm_req = 0; f_dm_we = 0; f_dm_addr = 0; f_dm_wdata = 0; f_dm_be_n = '1;
        for (int i = 0; i < 64; i++) begin
            r = $urandom();
            bus_mem[i] = r;
            gold[i]    = r;
        end
        bus_mem[4] = 32'h1234_5678;
        gold[4]    = 32'h1234_5678;
        last_if_rdata = '0;
        last_dm_rdata = '0;

        step();
        step();
        check_eq("rst_ce_n", 32'(ram_ce_n), 32'd1);
        check_eq("rst_oe_n", 32'(ram_oe_n), 32'd1);
        check_eq("rst_we_n", 32'(ram_we_n), 32'd1);
        check_eq("rst_be_n", 32'(ram_be_n), 32'hF);
        check_eq("rst_data_oe", 32'(ram_data_oe), 32'd0);
        check_eq("rst_addr", 32'(ram_addr), 32'd0);
        check_eq("rst_wdata", ram_wdata, 32'd0);
        check_eq("rst_ready", 32'({if_ready, dm_ready}), 32'd0);
        check_eq("rst_if_rdata", if_rdata, 32'd0);
        check_eq("rst_dm_rdata", dm_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Fetch of word 4 at 0x8000_0010.
        run_txn(1, 32'h8000_0010, 0, 0, 32'h0, 32'h0, 4'hF);
        check_eq("fetch_word4", last_if_rdata, 32'h1234_5678);

        // Halfword write to word 2 at 0x8040_0008.
        old = gold[2];
        run_txn(0, 32'h0, 1, 1, 32'h8040_0008, 32'hDEAD_BEEF, 4'b1100);
        check_eq("write_word2", bus_mem[2], {old[31:16], 16'hBEEF});

        // Simultaneous requests.
        run_txn(1, 32'h8000_0020, 1, 0, 32'h8000_0008, 32'h0, 4'h0);
        run_txn(1, 32'h8000_0008, 1, 1, 32'h0000_0008, 32'hCAFE_F00D, 4'b0110);

        for (int n = 0; n < 40; n++) begin
            int sel;
            sel = $urandom_range(0, 2);
            r = $urandom(); r2 = $urandom();
            a = $urandom();
            run_txn(sel != 1, {r[31:8], r2[5:0], r[1:0]},
                    sel != 0, 1'($urandom_range(0, 1)), {a[31:8], r2[13:8], a[1:0]},
                    $urandom(), 4'($urandom_range(0, 15)));
        end

        // Reset in the middle of a write pulse.
        dm_req = 1; dm_we = 1; dm_addr = 32'h0000_00FC; dm_wdata = $urandom(); dm_be_n = 4'h0;
        step();
        step();
        check_eq("abort_we_low_before", 32'(ram_we_n), 32'd0);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_we_n", 32'(ram_we_n), 32'd1);
        check_eq("abort_data_oe", 32'(ram_data_oe), 32'd0);
        check_eq("abort_ce_n", 32'(ram_ce_n), 32'd1);
        check_eq("abort_be_n", 32'(ram_be_n), 32'hF);
        check_eq("abort_addr", 32'(ram_addr), 32'd0);
        check_eq("abort_ready", 32'({if_ready, dm_ready}), 32'd0);
        dm_req = 0;
        last_if_rdata = '0;
        last_dm_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("abort_no_ready", 32'({if_ready, dm_ready}), 32'd0);
        end
        r = $urandom();
        run_txn(0, 32'h0, 1, 1, 32'h0000_00FC, r, 4'h0);
        run_txn(1, 32'h0000_00FC, 0, 0, 32'h0, 32'h0, 4'hF);

        // Back-to-back fetches on the zero-wait instance.
        r = $urandom();
        f_if_addr = r;
        f_if_req  = 1'b1;
        k = 0; last_k = 0; cnt = 0;
        while (cnt < 5 && k < 40) begin
            step();
            k++;
            if (f_if_ready) begin
                check_eq("fast_rdata", f_if_rdata, {12'h0, f_if_addr[21:2]});
                if (cnt == 0)
                    check_eq("fast_first_latency", 32'(k), 32'd2);
                else
                    check_eq("fast_gap", 32'(k - last_k), 32'd3);
                last_k = k;
                cnt++;
                f_if_addr = $urandom();
            end
        end
        check_eq("fast_count", 32'(cnt), 32'd5);
        f_if_req = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
